ahb_master_arbiter: RTL

- Round-robin arbiter and full AHB master-side multiplexer that shares the single CPU AHB port between NM bus units (TLB/PTW walker, L1 cache bus unit, external DMA requester).
- Grants ownership with a bus_req/bus_ack handshake and routes the owner's address/control/write-data onto the AHB.
- Routes hready/hresp back to the owner only.
- Sits between the bus units and the top-level AHB interface, in the BIU.

---
 rtl/ahb_master_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB master port between NM bus units.
// Grant/release uses bus_req/bus_ack; the owner's control and data are muxed onto the AHB.
module ahb_master_arbiter #(
  parameter int NM       = 3,
  parameter int HOLD_MAX = 256,
  parameter int CW       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    mst_bus_req,
  output logic [NM-1:0]    mst_bus_ack,
  output logic [NM-1:0]    mst_yield,
  input  logic [NM*64-1:0] mst_haddr,
  input  logic [NM-1:0]    mst_hwrite,
  input  logic [NM*4-1:0]  mst_hsize,
  input  logic [NM*3-1:0]  mst_hburst,
  input  logic [NM*4-1:0]  mst_hprot,
  input  logic [NM*2-1:0]  mst_htrans,
  input  logic [NM-1:0]    mst_hmastlock,
  input  logic [NM*64-1:0] mst_hwdata,
  output logic [NM-1:0]    mst_hready,
  output logic [NM-1:0]    mst_hresp,
  output logic [63:0]      mst_hrdata,
  output logic [63:0]      haddr,
  output logic             hwrite,
  output logic [3:0]       hsize,
  output logic [2:0]       hburst,
  output logic [3:0]       hprot,
  output logic [1:0]       htrans,
  output logic             hmastlock,
  output logic [63:0]      hwdata,
  input  logic             hready,
  input  logic             hresp,
  input  logic             hreset_n,
  input  logic [63:0]      hrdata,
  output logic [1:0]       o_dbg_state
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1, S_GAP = 2'd2} state_t;

  // Handshake: a master raises mst_bus_req and holds it for the whole ownership;
  // mst_bus_ack (registered, one-hot) follows one cycle after the request is sampled
  // in IDLE/GAP; dropping req while owning returns the bus after a one-cycle GAP.

  state_t          r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_ptr;
  logic [CW-1:0]   r_hold;
  logic [NM-1:0]   r_ack;
  logic            w_rst;
  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic            w_others;

  assign w_rst = rst | ~hreset_n;

  // Cyclic scan from r_ptr+1; descending loop so the nearest requester wins.
  always_comb begin
    logic [IW-1:0] v_idx;
    v_idx   = '0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = NM; k >= 1; k--) begin
      v_idx = IW'((int'(r_ptr) + k) % NM);
      if (mst_bus_req[v_idx]) begin
        w_found = 1'b1;
        w_pick  = v_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state <= S_IDLE;
      r_ack   <= '0;
      r_owner <= '0;
      r_ptr   <= IW'(NM - 1);
      r_hold  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_GAP: begin
          if (w_found) begin
            r_owner <= w_pick;
            r_ack   <= NM'(1) << w_pick;
            r_hold  <= '0;
            r_state <= S_GRANT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (!mst_bus_req[r_owner]) begin
            r_ptr   <= r_owner;
            r_ack   <= '0;
            r_state <= S_GAP;
          end
          if (r_hold != '1) r_hold <= r_hold + CW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    haddr     = '0;
    hwrite    = 1'b0;
    hsize     = '0;
    hburst    = '0;
    hprot     = '0;
    htrans    = 2'b00;
    hmastlock = 1'b0;
    hwdata    = '0;
    if (r_state == S_GRANT) begin
      for (int i = 0; i < NM; i++) begin
        if (r_owner == IW'(i)) begin
          haddr     = mst_haddr[64*i +: 64];
          hwrite    = mst_hwrite[i];
          hsize     = mst_hsize[4*i +: 4];
          hburst    = mst_hburst[3*i +: 3];
          hprot     = mst_hprot[4*i +: 4];
          htrans    = mst_htrans[2*i +: 2];
          hmastlock = mst_hmastlock[i];
          hwdata    = mst_hwdata[64*i +: 64];
        end
      end
    end
  end

  // Yield is only a hint; a locked sequence is never asked to break.
  assign w_others  = |(mst_bus_req & ~r_ack);
  assign mst_yield = ((r_state == S_GRANT) && (r_hold >= CW'(HOLD_MAX)) && w_others && !hmastlock)
                     ? r_ack : '0;

  assign mst_bus_ack = r_ack;
  assign mst_hready  = r_ack & {NM{hready}};
  assign mst_hresp   = r_ack & {NM{hresp}};
  assign mst_hrdata  = hrdata;
  assign o_dbg_state = r_state;

endmodule
